// File: rtl/bus_slot_arbiter.sv
// bus_slot_arbiter: time-division bus arbiter locked to the phi_2 frame strobe
//
// Ports:
//    clk       16 MHz system clock
//    reset     synchronous active-high reset
//    phi_2     one-cycle strobe marking T0 of each frame
//    cpu_req   CPU wants the bus this frame (sampled with phi_2)
//    fdc_req   FDC access request, level until fdc_ack
//    dbg_req   debug port access request, level until dbg_ack
//    gnt_cpu   CPU owns the bus
//    gnt_fdc   FDC owns the bus
//    gnt_dbg   debug port owns the bus
//    bus_sel   bus owner: 00 idle, 01 cpu, 10 fdc, 11 dbg
//    fdc_ack   FDC access complete pulse
//    dbg_ack   debug access complete pulse
//    slot      cycle index within the frame
//    locked    synchronised to phi_2
//    sync_err  sticky frame length violation flag
module bus_slot_arbiter #(
   parameter int FRAME_LEN = 8,
   parameter int CPU_SLOTS = 4,
   parameter int CNT_W     = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             phi_2,
   input  logic             cpu_req,
   input  logic             fdc_req,
   input  logic             dbg_req,
   output logic             gnt_cpu,
   output logic             gnt_fdc,
   output logic             gnt_dbg,
   output logic [1:0]       bus_sel,
   output logic             fdc_ack,
   output logic             dbg_ack,
   output logic [CNT_W-1:0] slot,
   output logic             locked,
   output logic             sync_err
);
   logic             rr, rr_n, t0, early, miss, pick, fin;
   logic             locked_n, err_n, cpu_n, fdc_n, dbg_n, fdc_ack_n, dbg_ack_n;
   logic [CNT_W-1:0] cnt_n;
   always_comb begin
      t0        = slot == '0;
      early     = locked & phi_2 & !t0;
      miss      = locked & !phi_2 & t0;
      locked_n  = phi_2 | (locked & !miss);
      err_n     = sync_err | early | miss;
      cnt_n     = phi_2 ? CNT_W'(1) : slot + 1'b1;
      // peripheral window owner chosen at the end of the last CPU slot
      pick      = locked & !phi_2 & (slot == CNT_W'(CPU_SLOTS));
      // last peripheral cycle (T0) follows the end of T(FRAME_LEN-1)
      fin       = !phi_2 & (slot == CNT_W'(FRAME_LEN - 1));
      cpu_n     = phi_2 ? cpu_req & locked_n : (miss | pick) ? 1'b0 : gnt_cpu;
      // any cycle leaving T0 (normal, early or missing strobe) ends the peripheral grant
      fdc_n     = pick ? fdc_req & (!dbg_req | !rr) : (phi_2 | t0) ? 1'b0 : gnt_fdc;
      dbg_n     = pick ? dbg_req & (!fdc_req | rr) : (phi_2 | t0) ? 1'b0 : gnt_dbg;
      rr_n      = (pick & fdc_req & dbg_req) ? !rr : rr;
      fdc_ack_n = fin & gnt_fdc;
      dbg_ack_n = fin & gnt_dbg;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         slot     <= '0;
         locked   <= 1'b0;
         sync_err <= 1'b0;
         gnt_cpu  <= 1'b0;
         gnt_fdc  <= 1'b0;
         gnt_dbg  <= 1'b0;
         bus_sel  <= 2'b00;
         fdc_ack  <= 1'b0;
         dbg_ack  <= 1'b0;
         rr       <= 1'b0;
      end else begin
         slot     <= cnt_n;
         locked   <= locked_n;
         sync_err <= err_n;
         gnt_cpu  <= cpu_n;
         gnt_fdc  <= fdc_n;
         gnt_dbg  <= dbg_n;
         bus_sel  <= {fdc_n | dbg_n, cpu_n | dbg_n};
         fdc_ack  <= fdc_ack_n;
         dbg_ack  <= dbg_ack_n;
         rr       <= rr_n;
      end
   end
endmodule

// File: tb/tb_bus_slot_arbiter.sv
// tb_bus_slot_arbiter: cycle-by-cycle vector table check of bus_slot_arbiter
module tb_bus_slot_arbiter;
  logic       clk = 1'b0, reset = 1'b1, phi_2 = 1'b0;
  logic       cpu_req = 1'b0, fdc_req = 1'b0, dbg_req = 1'b0;
  logic       gnt_cpu, gnt_fdc, gnt_dbg, fdc_ack, dbg_ack, locked, sync_err;
  logic [1:0] bus_sel;
  logic [2:0] slot;
  bus_slot_arbiter dut (
    .clk(clk), .reset(reset), .phi_2(phi_2), .cpu_req(cpu_req),
    .fdc_req(fdc_req), .dbg_req(dbg_req), .gnt_cpu(gnt_cpu),
    .gnt_fdc(gnt_fdc), .gnt_dbg(gnt_dbg), .bus_sel(bus_sel),
    .fdc_ack(fdc_ack), .dbg_ack(dbg_ack), .slot(slot),
    .locked(locked), .sync_err(sync_err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [4:0]  in;
    logic [11:0] exp;
  } vec_t;
  vec_t tbl[$];
  int total = 0, bad = 0;
  task automatic v(input logic r, p, c, f, d, gc, gf, gd, af, ad,
                   input int s, input logic lk, er);
    vec_t e;
    e.in  = {r, p, c, f, d};
    e.exp = {gc, gf, gd, gf | gd, gc | gd, af, ad, 3'(s), lk, er};
    tbl.push_back(e);
  endtask
  task automatic fr(input logic p, c, f, d, ec, input int own, input logic lk, er);
    for (int k = 0; k < 8; k++)
      v(1'b0, p && k == 0, c, f, d, ec && k < 4, own == 1 && k >= 4, own == 2 && k >= 4,
        own == 1 && k == 7, own == 2 && k == 7, (k + 1) % 8, lk, er);
  endtask
  initial begin
    #20000;
    bad++;
    $display("FAIL timeout: vector table did not complete");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    logic [11:0] obs;
    v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    fr(1, 1, 0, 0, 1, 0, 1, 0);
    fr(1, 1, 0, 0, 1, 0, 1, 0);
    fr(1, 0, 1, 1, 0, 1, 1, 0);
    fr(1, 0, 1, 1, 0, 2, 1, 0);
    fr(1, 0, 1, 1, 0, 1, 1, 0);
    fr(1, 0, 1, 1, 0, 2, 1, 0);
    fr(1, 0, 0, 1, 0, 2, 1, 0);
    fr(1, 0, 0, 1, 0, 2, 1, 0);
    fr(1, 0, 0, 1, 0, 2, 1, 0);
    fr(1, 0, 1, 1, 0, 1, 1, 0);
    v(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2, 1, 0);
    v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3, 1, 0);
    v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 4, 1, 0);
    v(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 5, 1, 0);
    v(0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 1, 1, 1);
    v(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 1, 1);
    v(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3, 1, 1);
    v(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4, 1, 1);
    v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 1, 1);
    v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 1, 1);
    v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 1, 1);
    v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    fr(1, 1, 0, 1, 1, 2, 1, 1);
    fr(0, 1, 0, 1, 0, 0, 0, 1);
    fr(1, 1, 0, 1, 1, 2, 1, 1);
    v(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1);
    v(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2, 1, 1);
    v(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3, 1, 1);
    v(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4, 1, 1);
    v(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 5, 1, 1);
    v(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 6, 1, 1);
    v(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    v(0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0);
    v(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 1, 0);
    @(posedge clk);
    #1;
    obs = {gnt_cpu, gnt_fdc, gnt_dbg, bus_sel, fdc_ack, dbg_ack, slot, locked, sync_err};
    total++;
    if (obs !== 12'b0) begin
      bad++;
      $display("FAIL reset state: got %b want all zero", obs);
    end
    @(negedge clk);
    foreach (tbl[i]) begin
      {reset, phi_2, cpu_req, fdc_req, dbg_req} = tbl[i].in;
      @(posedge clk);
      #1;
      obs = {gnt_cpu, gnt_fdc, gnt_dbg, bus_sel, fdc_ack, dbg_ack, slot, locked, sync_err};
      total++;
      if (obs !== tbl[i].exp) begin
        bad++;
        $display("FAIL row%0d {gc,gf,gd,sel,af,ad,slot,lk,err}: got %b want %b",
                 i, obs, tbl[i].exp);
      end
      @(negedge clk);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bus_slot_arbiter.md
Name: bus_slot_arbiter

Overview:
- Time-division arbiter for the shared system bus (RAM/ROM/IO) in the 16 MHz clock domain.
- Locks to the 2 MHz phi_2 strobe and divides each frame into two windows: a CPU window, and a peripheral window shared round-robin between the FDC data path and the debug port.
- Sits between the clock generator (phi_2 source) and the bus address/data muxes, which are steered by bus_sel.

Parameters:
- FRAME_LEN, 8, clk cycles per phi_2 frame; must equal the clock generator divide ratio; power of two, at least 4.
- CPU_SLOTS, 4, cycles per frame reserved for the CPU; range 1 to FRAME_LEN-2.
- CNT_W, 3, width of the slot counter; equals log2(FRAME_LEN).

Ports:
- clk  in  1  16 MHz system clock, the only clock.
- reset  in  1  synchronous, active-high reset.
- phi_2  in  1  one-cycle strobe; marks cycle T0 of each frame.
- cpu_req  in  1  CPU requests the bus this frame; sampled only when phi_2=1.
- fdc_req  in  1  FDC requests an access; level, held until fdc_ack.
- dbg_req  in  1  debug port requests an access; level, held until dbg_ack.
- gnt_cpu  out  1  CPU owns the bus.
- gnt_fdc  out  1  FDC owns the bus.
- gnt_dbg  out  1  debug port owns the bus.
- bus_sel  out  2  bus owner: 00 idle, 01 cpu, 10 fdc, 11 dbg.
- fdc_ack  out  1  one-cycle pulse, FDC access complete.
- dbg_ack  out  1  one-cycle pulse, debug access complete.
- slot  out  CNT_W  current cycle index within the frame.
- locked  out  1  arbiter is synchronised to phi_2.
- sync_err  out  1  sticky flag, frame length violation seen.

Behaviour:
- All outputs are registered. Reset value of every output is 0. Reset also sets the round-robin pointer rr to "fdc first".
- Reset mid-access: all grants drop on the next edge and no ack is issued.
- Slot counter:
  - On phi_2=1: cnt <= 1.
  - Otherwise: cnt <= cnt+1, wrapping from FRAME_LEN-1 to 0.
  - slot = cnt.
  - In a correct frame, cnt=0 during the phi_2 cycle.
- Lock:
  - locked=0 after reset.
  - The first phi_2 sets locked=1.
  - No grants are issued while locked=0.
- CPU window:
  - Decided at the edge ending a phi_2 cycle: gnt_cpu <= cpu_req & locked_next.
  - gnt_cpu is held for cycles T1..T(CPU_SLOTS), then cleared.
  - Idle CPU windows are not lent to peripherals.
- Peripheral window:
  - Decided at the edge ending the cycle where cnt==CPU_SLOTS.
  - If only one requester is active, that requester wins.
  - If both are active, rr decides, and rr then flips to the other requester.
  - The grant is held for cycles T(CPU_SLOTS+1)..T(FRAME_LEN), where T(FRAME_LEN) is the next frame's T0.
  - The owner's ack pulses in that final cycle, coincident with its last grant cycle.
  - If no requester is active, the window is idle and rr is unchanged.
- A requester dropping req mid-grant does not abort the access; the grant and ack still complete.
- Peripheral and CPU grants never overlap: the peripheral grant ends in T0 and the CPU grant starts in T1.
- At most one gnt_* is high in any cycle; bus_sel always encodes the active grant.
- Early phi_2 (phi_2=1 while locked and cnt!=0):
  - Set sync_err.
  - Clear any peripheral grant with no ack.
  - Clear gnt_cpu, then restart the frame: cnt <= 1 and cpu_req is sampled as usual.
- Missing phi_2 (locked and cnt==0 but phi_2=0):
  - Set sync_err and locked <= 0.
  - Clear all grants with no ack.
  - Wait for the next phi_2 to relock.
- sync_err is cleared only by reset.

Test Plan:
- Reset, then phi_2 every 8 cycles with cpu_req=1 -> locked=1 after the first strobe; gnt_cpu and bus_sel=01 high in T1..T4 of every frame; slot sequences 1..7,0.
- fdc_req=1 and dbg_req=1 held, cpu_req=0 -> grants alternate fdc, dbg, fdc across frames in cycles T5..T0; fdc_ack/dbg_ack pulse exactly in T0; gnt_cpu never set.
- Only dbg_req=1 for three frames -> dbg granted every frame; rr unchanged, so a later simultaneous request grants fdc first.
- phi_2 arrives at cnt=5 during an fdc grant -> sync_err=1; gnt_fdc=0 next cycle; no fdc_ack; gnt_cpu in the following 4 cycles if cpu_req=1.
- phi_2 withheld at cnt=0 -> locked=0, sync_err=1, no grants until the next phi_2, then normal operation resumes with sync_err still 1.
- reset asserted in T6 during a dbg grant -> all outputs 0 at the next edge; no dbg_ack; relock on the next phi_2.
